sync_fifo_param: RTL

Parametrised single-clock FIFO. It is the generalised successor to the team's fixed 256x9 FIFO block, with configurable data width and depth, status flags, an occupancy count and overflow/underflow error pulses. Read data is registered with a valid qualifier and never tri-states. It sits between datapath producers and consumers inside one clock domain.

---
 rtl/sync_fifo_param.sv | 66 ++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered read data, status flags,
// occupancy count and overflow/underflow pulses.
module sync_fifo_param #(
    parameter int DATA_W   = 9,
    parameter int ADDR_W   = 8,
    parameter int AF_LEVEL = 2**ADDR_W - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_ptr_clr,
    input  logic              rd_ptr_clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W:0]   wptr, rptr;
    logic              wr_acc, rd_acc;

    // The extra pointer MSB lets a full FIFO be told apart from an empty one.
    assign count        = wptr - rptr;
    assign full         = count == DEPTH_C;
    assign empty        = count == '0;
    assign almost_full  = count >= AF_C;
    assign almost_empty = count <= AE_C;
    assign wr_acc       = wr_en && !full && !wr_ptr_clr;
    assign rd_acc       = rd_en && !empty && !rd_ptr_clr;

    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem[wptr[ADDR_W-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wptr       <= wr_ptr_clr ? '0 : wr_acc ? wptr + ONE : wptr;
            rptr       <= rd_ptr_clr ? '0 : rd_acc ? rptr + ONE : rptr;
            dout       <= rd_acc ? mem[rptr[ADDR_W-1:0]] : dout;
            dout_valid <= rd_acc;
            overflow   <= wr_en && full;
            underflow  <= rd_en && empty;
        end
    end
endmodule
